sid_filter_sched: RTL and testbench



---
 rtl/sid_pkg.sv | 21 ++
 rtl/sid_tick_div.sv | 25 ++
 rtl/sid_filter_sched.sv | 120 ++++++++++++
 tb/tb_sid_filter_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared constants and types for the SID filter sequencer.
package sid_pkg;

  // Filter register addresses as seen on reg_addr
  localparam logic [1:0] FC_LO    = 2'd0;
  localparam logic [1:0] FC_HI    = 2'd1;
  localparam logic [1:0] RES_FILT = 2'd2;
  localparam logic [1:0] MODE_VOL = 2'd3;

  // Datapath widths
  localparam int VOICE_W = 13;
  localparam int SOUND_W = 19;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/sid_tick_div.sv
// Free-running clock divider producing a one-cycle sample tick every CLK_DIV cycles.
module sid_tick_div #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..CLK_DIV-1 and wrap; never stalls on sequencer state.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                  div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/sid_filter_sched.sv
// Sample-rate sequencer for sid_filters: snapshots registers and voices on each
// tick, launches one filter computation, captures the result, reports faults.
module sid_filter_sched
  import sid_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int TIMEOUT = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_we,
  input  logic [1:0]                reg_addr,
  input  logic [7:0]                reg_wdata,
  input  logic signed [VOICE_W-1:0] voice1,
  input  logic signed [VOICE_W-1:0] voice2,
  input  logic signed [VOICE_W-1:0] voice3,
  input  logic signed [VOICE_W-1:0] ext_in,
  output logic [7:0]                f_Fc_lo,
  output logic [7:0]                f_Fc_hi,
  output logic [7:0]                f_Res_Filt,
  output logic [7:0]                f_Mode_Vol,
  output logic signed [VOICE_W-1:0] f_voice1,
  output logic signed [VOICE_W-1:0] f_voice2,
  output logic signed [VOICE_W-1:0] f_voice3,
  output logic signed [VOICE_W-1:0] f_ext_in,
  output logic                      f_input_valid,
  input  logic [SOUND_W-1:0]        f_sound,
  input  logic                      f_valid,
  output logic [SOUND_W-1:0]        sample_out,
  output logic                      sample_strobe,
  output logic                      busy,
  output logic [7:0]                overrun_cnt,
  output logic                      timeout_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic       tick;
  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] staging [4];

  sid_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Staging writes, tick-driven launch, result capture and fault tracking.
  // NOTE: staging is only four bytes and its reset value is visible at the first
  // launch, so it is reset like ordinary flops rather than left as an unreset RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      staging       <= '{default: '0};
      f_Fc_lo       <= '0;
      f_Fc_hi       <= '0;
      f_Res_Filt    <= '0;
      f_Mode_Vol    <= '0;
      f_voice1      <= '0;
      f_voice2      <= '0;
      f_voice3      <= '0;
      f_ext_in      <= '0;
      f_input_valid <= 1'b0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      overrun_cnt   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      f_input_valid <= 1'b0;
      sample_strobe <= 1'b0;

      // A write in the launch cycle lands after the snapshot below reads staging.
      if (reg_we) staging[reg_addr] <= reg_wdata;

      // Any tick seen while a launch is outstanding is dropped and counted.
      if (tick && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (tick) begin
            f_Fc_lo       <= staging[FC_LO];
            f_Fc_hi       <= staging[FC_HI];
            f_Res_Filt    <= staging[RES_FILT];
            f_Mode_Vol    <= staging[MODE_VOL];
            f_voice1      <= voice1;
            f_voice2      <= voice2;
            f_voice3      <= voice3;
            f_ext_in      <= ext_in;
            f_input_valid <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (f_valid) begin
            sample_out    <= f_sound;
            sample_strobe <= 1'b1;
            state         <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sid_filter_sched.sv
// Self-checking bench for sid_filter_sched: a stub filter answers each launch
// after a programmable delay, a cycle-indexed reference model predicts every
// output, and directed scenarios pin the model with literal expectations.
module tb_sid_filter_sched;
  import sid_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int TIMEOUT = 24;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      reg_we;
  logic [1:0]                reg_addr;
  logic [7:0]                reg_wdata;
  logic signed [VOICE_W-1:0] voice1, voice2, voice3, ext_in;
  logic [7:0]                f_Fc_lo, f_Fc_hi, f_Res_Filt, f_Mode_Vol;
  logic signed [VOICE_W-1:0] f_voice1, f_voice2, f_voice3, f_ext_in;
  logic                      f_input_valid;
  logic [SOUND_W-1:0]        f_sound;
  logic                      f_valid;
  logic [SOUND_W-1:0]        sample_out;
  logic                      sample_strobe;
  logic                      busy;
  logic [7:0]                overrun_cnt;
  logic                      timeout_err;

  sid_filter_sched #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .voice1(voice1), .voice2(voice2), .voice3(voice3), .ext_in(ext_in),
    .f_Fc_lo(f_Fc_lo), .f_Fc_hi(f_Fc_hi), .f_Res_Filt(f_Res_Filt), .f_Mode_Vol(f_Mode_Vol),
    .f_voice1(f_voice1), .f_voice2(f_voice2), .f_voice3(f_voice3), .f_ext_in(f_ext_in),
    .f_input_valid(f_input_valid), .f_sound(f_sound), .f_valid(f_valid),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_cyc is the index of the current cycle since reset was released; a launch
  // issued in cycle m_lc is answered when f_valid arrives at age 1..TIMEOUT,
  // or abandoned at age TIMEOUT.
  bit                  m_ready = 1'b0;
  int                  m_cyc, m_lc, m_age;
  bit                  m_active, m_tick;
  logic [7:0]          m_stg [4];
  logic [7:0]          e_regs [4];
  logic signed [12:0]  e_v1, e_v2, e_v3, e_ext;
  logic                e_fiv, e_strobe, e_terr;
  logic [SOUND_W-1:0]  e_sample;
  int                  e_ovr;

  always @(posedge clk) begin
    if (rst) begin
      m_ready  = 1'b1;
      m_cyc    = 0;
      m_lc     = 0;
      m_active = 1'b0;
      for (int i = 0; i < 4; i++) begin m_stg[i] = '0; e_regs[i] = '0; end
      e_v1 = '0; e_v2 = '0; e_v3 = '0; e_ext = '0;
      e_fiv = 1'b0; e_strobe = 1'b0; e_terr = 1'b0; e_sample = '0; e_ovr = 0;
    end else if (m_ready) begin
      m_tick   = (m_cyc % CLK_DIV) == CLK_DIV - 1;
      e_fiv    = 1'b0;
      e_strobe = 1'b0;
      if (m_active) begin
        m_age = m_cyc - m_lc;
        if (m_age >= 1 && f_valid) begin
          e_sample = f_sound; e_strobe = 1'b1; m_active = 1'b0;
        end else if (m_age == TIMEOUT) begin
          e_terr = 1'b1; m_active = 1'b0;
        end
        if (m_tick && e_ovr < 255) e_ovr++;
      end else if (m_tick) begin
        for (int i = 0; i < 4; i++) e_regs[i] = m_stg[i];
        e_v1 = voice1; e_v2 = voice2; e_v3 = voice3; e_ext = ext_in;
        e_fiv    = 1'b1;
        m_active = 1'b1;
        m_lc     = m_cyc + 1;
      end
      if (reg_we) m_stg[reg_addr] = reg_wdata;
      m_cyc++;
    end
  end

  // Compare every output against the model each cycle, mid-cycle.
  always @(negedge clk) begin
    if (m_ready) begin
      check("f_Fc_lo",       f_Fc_lo,       e_regs[0]);
      check("f_Fc_hi",       f_Fc_hi,       e_regs[1]);
      check("f_Res_Filt",    f_Res_Filt,    e_regs[2]);
      check("f_Mode_Vol",    f_Mode_Vol,    e_regs[3]);
      check("f_voice1",      f_voice1,      e_v1);
      check("f_voice2",      f_voice2,      e_v2);
      check("f_voice3",      f_voice3,      e_v3);
      check("f_ext_in",      f_ext_in,      e_ext);
      check("f_input_valid", f_input_valid, e_fiv);
      check("sample_out",    sample_out,    e_sample);
      check("sample_strobe", sample_strobe, e_strobe);
      check("busy",          busy,          m_active);
      check("overrun_cnt",   overrun_cnt,   e_ovr[7:0]);
      check("timeout_err",   timeout_err,   e_terr);
    end
  end

  // ---------------- stimulus and stub filter ----------------
  int                 tcyc     = 0;
  int                 reply_at = -1;
  int                 stub_n   = 13;
  bit                 rand_stub = 1'b0;
  logic [SOUND_W-1:0] stub_sound = '0;

  // Advance to the middle of the next cycle and drive that cycle's inputs.
  task automatic step();
    int r;
    @(negedge clk);
    f_valid   = (tcyc == reply_at);
    f_sound   = f_valid ? stub_sound : SOUND_W'($urandom);
    voice1    = 13'($urandom);
    voice2    = 13'($urandom);
    voice3    = 13'($urandom);
    ext_in    = 13'($urandom);
    reg_we    = 1'b0;
    reg_addr  = 2'($urandom);
    reg_wdata = 8'($urandom);
    if (f_input_valid) begin
      if (rand_stub) begin
        r          = $urandom_range(0, 27);
        stub_n     = (r == 0) ? -1 : r;
        stub_sound = SOUND_W'($urandom);
      end
      reply_at = (stub_n < 0) ? -1 : tcyc + stub_n;
    end
    tcyc++;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  task automatic wait_launch(input int budget, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      step(); n++;
      if (f_input_valid) found = 1'b1;
    end
    if (!found) check("launch_seen", f_input_valid, 1'b1);
  endtask

  task automatic wait_strobe(input int budget, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      step(); n++;
      if (sample_strobe) found = 1'b1;
    end
    if (!found) check("strobe_seen", sample_strobe, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    voice1 = '0; voice2 = '0; voice3 = '0; ext_in = '0;
    f_valid = 1'b0; f_sound = '0;
    step(); step();
    rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_sample_out", sample_out, '0);

    // 1: register writes reach the filter; reply after 13 cycles
    stub_n = 13; stub_sound = 19'h12345;
    step(); reg_we = 1'b1; reg_addr = FC_HI;    reg_wdata = 8'h40;
    step(); reg_we = 1'b1; reg_addr = MODE_VOL; reg_wdata = 8'h1F;
    wait_launch(40, n);
    check("t1_fc_hi", f_Fc_hi, 8'h40);
    check("t1_mode_vol", f_Mode_Vol, 8'h1F);
    wait_strobe(40, n);
    check("t1_strobe_latency", n, 14);
    check("t1_sample", sample_out, 19'h12345);
    step();
    check("t1_strobe_single", sample_strobe, 1'b0);

    // 2: write in the tick cycle applies one launch later
    reg_we = 1'b1; reg_addr = FC_LO; reg_wdata = 8'h11;
    do step(); while (m_cyc % CLK_DIV != CLK_DIV - 1);
    reg_we = 1'b1; reg_addr = FC_LO; reg_wdata = 8'hAA;
    wait_launch(40, n);
    check("t2_launch_latency", n, 1);
    check("t2_fc_lo_old", f_Fc_lo, 8'h11);
    wait_launch(40, n);
    check("t2_fc_lo_new", f_Fc_lo, 8'hAA);

    // 3: slow filter drops every other tick; overrun saturates
    do_reset();
    stub_n = 20; stub_sound = 19'h2A5A5;
    for (int k = 1; k <= 300; k++) begin
      wait_launch(40, n);
      if (k == 2) check("t3_ovr_1", overrun_cnt, 8'd1);
      if (k == 3) check("t3_ovr_2", overrun_cnt, 8'd2);
    end
    repeat (30) step();
    check("t3_ovr_sat", overrun_cnt, 8'd255);
    check("t3_no_timeout", timeout_err, 1'b0);

    // 4: filter never answers
    stub_n = -1;
    wait_launch(40, n);
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      check("t4_err_early", timeout_err, 1'b0);
    end
    step();
    check("t4_err_set", timeout_err, 1'b1);
    check("t4_busy_fall", busy, 1'b0);
    check("t4_sample_held", sample_out, 19'h2A5A5);
    wait_launch(16, n);
    check("t4_relaunch", n, 7);

    // 5: reset in the middle of WAIT; the late reply is ignored
    stub_n = 13; stub_sound = 19'h55555;
    wait_launch(40, n);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_sample", sample_out, '0);
    check("t5_err", timeout_err, 1'b0);
    check("t5_ovr", overrun_cnt, 8'd0);
    wait_launch(40, n);
    check("t5_first_launch", n, 16);

    // 6: stray f_valid in IDLE produces nothing
    wait_strobe(40, n);
    step();
    f_valid = 1'b1; f_sound = 19'h7FFFF;
    step();
    check("t6_no_strobe", sample_strobe, 1'b0);
    check("t6_sample_kept", sample_out, 19'h55555);

    // Randomized traffic: writes, reply delays across the timeout edge, stray strobes, resets
    rand_stub = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) reg_we = 1'b1;
      if (!f_valid && $urandom_range(0, 40) == 0) f_valid = 1'b1;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    step(); rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
